uart_tx_word: RTL and testbench

- Transmit-side counterpart to the UART receive path (uart_rx + uart_sr): serializes one 16-bit word as two 8N1 UART frames on a single TX line.
- High byte is sent first, so that a uart_rx/uart_sr pair at the far end reassembles the same word.
- Runs on sysclk (50 MHz); intended to drive a GPIO pin so the board can return memory words/debug data to the host.

---
 rtl/uart_tx_word.sv | 111 +++++++++++
 tb/tb_uart_tx_word.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word.sv
// UART word transmitter: sends one 16-bit word as two 8N1 frames,
// high byte first, on a single idle-high TX line.
module uart_tx_word #(
   parameter int CLKS_PER_BIT = 434,
   parameter int WORD_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  word_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]            state;
   logic [CW-1:0]         cnt;
   logic [2:0]            bit_idx;
   logic                  byte_sel;
   logic [WORD_WIDTH-1:0] shift_word;
   logic [7:0]            cur_byte;
   logic                  bit_end;

   assign cur_byte = byte_sel ? shift_word[7:0] : shift_word[15:8];
   assign bit_end  = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         byte_sel   <= 1'b0;
         shift_word <= '0;
         tx         <= 1'b1;
         word_ready <= 1'b1;
         busy       <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         word_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (word_valid && word_ready) begin
                  shift_word <= word_in;
                  word_ready <= 1'b0;
                  busy       <= 1'b1;
                  tx         <= 1'b0;
                  state      <= START;
                  byte_sel   <= 1'b0;
                  cnt        <= '0;
                  bit_idx    <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (!byte_sel) begin
                     // second frame follows with no idle gap
                     byte_sel <= 1'b1;
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     byte_sel   <= 1'b0;
                     word_ready <= 1'b1;
                     busy       <= 1'b0;
                     word_done  <= 1'b1;
                     state      <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word at 4 clocks per bit: tx line captured per cycle
// and compared with frame levels built from the word.
module tb_uart_tx_word;

   localparam int CPB = 4;
   localparam int TXN = 20 * CPB;

   logic        clk;
   logic        rst;
   logic [15:0] word_in;
   logic        word_valid;
   logic        word_ready;
   logic        tx;
   logic        busy;
   logic        word_done;

   int checks = 0;
   int errors = 0;

   uart_tx_word #(.CLKS_PER_BIT(CPB), .WORD_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .tx         (tx),
      .busy       (busy),
      .word_done  (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line level for each cycle after the accept edge.
   function automatic logic [127:0] exp_line(input logic [15:0] w);
      logic [127:0] r;
      logic [19:0]  bits;
      logic [7:0]   byt;
      r = '1;
      for (int j = 0; j < 2; j++) begin
         byt = (j == 0) ? w[15:8] : w[7:0];
         bits[j*10] = 1'b0;
         for (int i = 0; i < 8; i++) bits[j*10+1+i] = byt[i];
         bits[j*10+9] = 1'b1;
      end
      for (int k = 0; k < TXN; k++) r[k] = bits[k/CPB];
      return r;
   endfunction

   // Called right after an accept edge; samples ncyc negedges.
   task automatic capture(input int ncyc, input logic hold,
                          input int inj_cyc, input logic [15:0] inj,
                          output logic [127:0] txv, output int dcnt,
                          output int dat, output int rat,
                          output int bbad);
      txv = '1; dcnt = 0; dat = -1; rat = -1; bbad = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         txv[k] = tx;
         if (word_done) begin
            dcnt++;
            if (dat < 0) dat = k;
         end
         if (word_ready && rat < 0) rat = k;
         if (busy !== ~word_ready) bbad++;
         if (k == 0 && !hold) word_valid = 1'b0;
         if (k == inj_cyc) begin
            word_valid = 1'b1;
            word_in    = inj;
         end
         if (k == inj_cyc + 1) word_valid = 1'b0;
      end
   endtask

   task automatic accept(input logic [15:0] w);
      @(negedge clk);
      word_in    = w;
      word_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0; word_valid = 1'b1; word_in = 16'h5555;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || word_ready !== 1'b1 ||
             busy !== 1'b0 || word_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx=%b rdy=%b busy=%b done=%b req 1 1 0 0",
                     tx, word_ready, busy, word_done);
         end
      end
      word_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single(input logic [15:0] w, input string nm);
      logic [127:0] txv, e;
      int dc, da, ra, bb;
      e = exp_line(w);
      accept(w);
      capture(TXN + 4, 1'b0, -5, 16'h0, txv, dc, da, ra, bb);
      checks++;
      if (txv[TXN-1:0] !== e[TXN-1:0]) begin
         errors++;
         $display("FAIL %s tx: got %h req %h", nm, txv[TXN-1:0], e[TXN-1:0]);
      end
      checks++;
      if (dc !== 1 || da !== TXN) begin
         errors++;
         $display("FAIL %s done: cnt=%0d at=%0d req 1 at %0d", nm, dc, da, TXN);
      end
      checks++;
      if (ra !== TXN) begin
         errors++;
         $display("FAIL %s ready: at %0d req %0d", nm, ra, TXN);
      end
      checks++;
      if (bb !== 0) begin
         errors++;
         $display("FAIL %s busy: %0d bad cycles req 0", nm, bb);
      end
   endtask

   task automatic test_ignore_busy;
      logic [127:0] txv, e;
      int dc, da, ra, bb;
      e = exp_line(16'h00FF);
      accept(16'h00FF);
      capture(TXN + 10, 1'b0, 10, 16'h1234, txv, dc, da, ra, bb);
      checks++;
      if (txv[TXN+9:0] !== e[TXN+9:0]) begin
         errors++;
         $display("FAIL ignore tx: got %h req %h", txv[TXN+9:0], e[TXN+9:0]);
      end
      checks++;
      if (dc !== 1) begin
         errors++;
         $display("FAIL ignore done: cnt=%0d req 1", dc);
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] txv, e;
      int dc, da, ra, bb;
      e = exp_line(16'h0001);
      accept(16'h0001);
      capture(TXN + 1, 1'b1, -5, 16'h0, txv, dc, da, ra, bb);
      word_in = 16'h8000;
      checks++;
      if (txv[TXN-1:0] !== e[TXN-1:0] || txv[TXN] !== 1'b1 || dc !== 1) begin
         errors++;
         $display("FAIL b2b first: got %h stop=%b done=%0d req %h 1 1",
                  txv[TXN-1:0], txv[TXN], dc, e[TXN-1:0]);
      end
      @(posedge clk);
      e = exp_line(16'h8000);
      capture(TXN + 2, 1'b0, -5, 16'h0, txv, dc, da, ra, bb);
      checks++;
      if (txv[TXN-1:0] !== e[TXN-1:0]) begin
         errors++;
         $display("FAIL b2b second tx: got %h req %h", txv[TXN-1:0], e[TXN-1:0]);
      end
      checks++;
      if (dc !== 1 || da !== TXN) begin
         errors++;
         $display("FAIL b2b second done: cnt=%0d at=%0d req 1 at %0d",
                  dc, da, TXN);
      end
   endtask

   task automatic test_reset_mid;
      logic [127:0] txv;
      int dc, da, ra, bb;
      accept(16'hFFFF);
      capture(30, 1'b0, -5, 16'h0, txv, dc, da, ra, bb);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: tx=%b rdy=%b busy=%b req 1 1 0",
                  tx, word_ready, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      dc = 0;
      for (int i = 0; i < TXN; i++) begin
         @(negedge clk);
         if (word_done || !tx) dc++;
      end
      checks++;
      if (dc !== 0) begin
         errors++;
         $display("FAIL rst_mid quiet: %0d active cycles req 0", dc);
      end
      test_single(16'h1234, "after_rst");
   endtask

   task automatic test_random;
      logic [15:0] w;
      for (int n = 0; n < 4; n++) begin
         w = 16'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         test_single(w, "random");
      end
   endtask

   initial begin
      rst = 1'b0; word_valid = 1'b0; word_in = '0;
      test_reset;
      test_single(16'hA55A, "single");
      test_ignore_busy;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
